// File: rtl/shared_ram_arb_pkg.sv
// shared_ram_arb_pkg
// Purpose: shared widths and the FSM state type for shared_ram_arbiter and
//          its testbench-free helpers.
// Contents:
//   LINE_W       width of one RAM line / core data bus
//   BE_W         byte enables per line
//   RAM_ADDR_W   address bits the RAM actually decodes
//   CORE_ADDR_W  width of a core's ALU_result address
//   arb_state_t  IDLE / ACCESS / RESPOND
package shared_ram_arb_pkg;

    localparam int LINE_W      = 128;
    localparam int BE_W        = 16;
    localparam int RAM_ADDR_W  = 20;
    localparam int CORE_ADDR_W = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RESPOND = 2'd2
    } arb_state_t;

endpackage

// File: rtl/shared_ram_arbiter_rr_picker.sv
// rr_picker
// Purpose: purely combinational round-robin select. Returns the first set
//          bit of req at or after ptr, scanning upward modulo N.
// Ports:
//   req        in  N      request vector
//   ptr        in  IDX_W  index that currently has highest priority
//   grant_idx  out IDX_W  selected requester (0 when nothing requests)
//   any        out 1      at least one request bit is set
module rr_picker #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] grant_idx,
    output logic             any
);

    // Offsets are visited from the farthest back toward ptr, so the
    // requester closest to ptr is written last and wins.
    always_comb begin
        grant_idx = '0;
        any       = 1'b0;
        for (int off = N - 1; off >= 0; off--) begin
            if (req[(int'(ptr) + off) % N]) begin
                grant_idx = IDX_W'((int'(ptr) + off) % N);
                any       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/shared_ram_arbiter.sv
// shared_ram_arbiter
// Purpose: round-robin arbiter between N_CORES core data ports and one
//          shared single-port 128-bit RAM. One transaction is in flight at a
//          time; every granted request gets exactly one core_ready pulse.
// Optional feature: define SHARED_RAM_ARB_PERF_EN to add per-core grant
//          counters and a global stall counter (saturating, 32 bit).
// Ports:
//   clock, reset          clock and synchronous active-high reset
//   core_req/we           per-core request level and write flag
//   core_addr/wdata/be    per-core address, write line, byte enables
//   core_ready            one-hot, one-cycle completion pulse
//   resp_data             captured RAM line, valid while core_ready != 0
//   ram_address/data_in/byte_enablers/write_enable   registered RAM drive
//   ram_data_out          RAM read data
//   grant_count, stall_count   (SHARED_RAM_ARB_PERF_EN only)
module shared_ram_arbiter
    import shared_ram_arb_pkg::*;
#(
    parameter int N_CORES     = 4,
    parameter int RAM_LATENCY = 1
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [N_CORES-1:0]             core_req,
    input  logic [N_CORES-1:0]             core_we,
    input  logic [N_CORES*CORE_ADDR_W-1:0] core_addr,
    input  logic [N_CORES*LINE_W-1:0]      core_wdata,
    input  logic [N_CORES*BE_W-1:0]        core_be,
    output logic [N_CORES-1:0]             core_ready,
    output logic [LINE_W-1:0]              resp_data,
    output logic [RAM_ADDR_W-1:0]          ram_address,
    output logic [LINE_W-1:0]              ram_data_in,
    output logic [BE_W-1:0]                ram_byte_enablers,
    output logic                           ram_write_enable,
`ifdef SHARED_RAM_ARB_PERF_EN
    output logic [N_CORES*32-1:0]          grant_count,
    output logic [31:0]                    stall_count,
`endif
    input  logic [LINE_W-1:0]              ram_data_out
);

    localparam int                IDX_W     = $clog2(N_CORES);
    localparam int                WAIT_W    = 2;
    localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(RAM_LATENCY - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(N_CORES - 1);

    arb_state_t              state_q;
    logic [IDX_W-1:0]        rr_ptr_q;
    logic [IDX_W-1:0]        grant_q;
    logic [WAIT_W-1:0]       wait_q;
    logic [N_CORES-1:0]      ready_q;
    logic [LINE_W-1:0]       resp_q;
    logic [RAM_ADDR_W-1:0]   addr_q;
    logic [LINE_W-1:0]       wdata_q;
    logic [BE_W-1:0]         be_q;
    logic                    we_q;

    logic [IDX_W-1:0]        grant_d;
    logic                    any_req;

    logic [RAM_ADDR_W-1:0]   addr_arr  [N_CORES];
    logic [LINE_W-1:0]       wdata_arr [N_CORES];
    logic [BE_W-1:0]         be_arr    [N_CORES];
    logic                    unused_addr_hi;

    // Split the flat per-core buses into arrays. Address bits above the RAM's
    // decode range are dropped on purpose; they are folded into a dummy net
    // only so they do not look like forgotten inputs.
    always_comb begin
        unused_addr_hi = 1'b0;
        for (int i = 0; i < N_CORES; i++) begin
            addr_arr[i]    = core_addr[i*CORE_ADDR_W +: RAM_ADDR_W];
            wdata_arr[i]   = core_wdata[i*LINE_W +: LINE_W];
            be_arr[i]      = core_be[i*BE_W +: BE_W];
            unused_addr_hi = unused_addr_hi
                           ^ (^core_addr[i*CORE_ADDR_W+RAM_ADDR_W +: CORE_ADDR_W-RAM_ADDR_W]);
        end
    end

    rr_picker #(
        .N     (N_CORES),
        .IDX_W (IDX_W)
    ) u_picker (
        .req       (core_req),
        .ptr       (rr_ptr_q),
        .grant_idx (grant_d),
        .any       (any_req)
    );

    // Transaction FSM. RAM drive is latched on the IDLE->ACCESS edge and held
    // until the next grant; the write strobe lives for the first ACCESS cycle
    // only. core_ready is set on the edge into RESPOND so it is high for that
    // one cycle, during which requests are deliberately not sampled.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            wait_q   <= '0;
            ready_q  <= '0;
            resp_q   <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            be_q     <= '0;
            we_q     <= 1'b0;
        end else begin
            ready_q <= '0;
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        grant_q <= grant_d;
                        addr_q  <= addr_arr[grant_d];
                        wdata_q <= wdata_arr[grant_d];
                        be_q    <= be_arr[grant_d];
                        we_q    <= core_we[grant_d];
                        wait_q  <= WAIT_INIT;
                        state_q <= ACCESS;
                    end
                end
                ACCESS: begin
                    we_q <= 1'b0;
                    if (wait_q == '0) begin
                        resp_q           <= ram_data_out;
                        ready_q[grant_q] <= 1'b1;
                        state_q          <= RESPOND;
                    end else begin
                        wait_q <= wait_q - 1'b1;
                    end
                end
                RESPOND: begin
                    rr_ptr_q <= (grant_q == LAST_IDX) ? '0 : grant_q + 1'b1;
                    state_q  <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign core_ready        = ready_q;
    assign resp_data         = resp_q;
    assign ram_address       = addr_q;
    assign ram_data_in       = wdata_q;
    assign ram_byte_enablers = be_q;
    assign ram_write_enable  = we_q;

`ifdef SHARED_RAM_ARB_PERF_EN
    logic [31:0] grant_cnt_q [N_CORES];
    logic [31:0] stall_cnt_q;

    // ready_q is only nonzero in RESPOND and is then one-hot on the served
    // core, so it doubles as the "being responded to" mask for both counters.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < N_CORES; i++) begin
                grant_cnt_q[i] <= '0;
            end
            stall_cnt_q <= '0;
        end else begin
            for (int i = 0; i < N_CORES; i++) begin
                if (ready_q[i] && (grant_cnt_q[i] != '1)) begin
                    grant_cnt_q[i] <= grant_cnt_q[i] + 32'd1;
                end
            end
            if (((core_req & ~ready_q) != '0) && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    for (genvar g = 0; g < N_CORES; g++) begin : g_grant_pack
        assign grant_count[g*32 +: 32] = grant_cnt_q[g];
    end
    assign stall_count = stall_cnt_q;
`endif

endmodule

// File: doc/shared_ram_arbiter.md
# shared_ram_arbiter

Round-robin arbiter between `N_CORES` RV32I core data ports and one shared single-port 128-bit data RAM (`RAM_1p_8g_20a_128b`). It sits directly downstream of each core's data-memory outputs (`memory_transaction`, `mem_write`, `ALU_result`, `data_out_bus`, `byte_enablers`). It replaces the per-core `MT_FSM` as the source of `data_ready`, serialising accesses and returning read lines. One transaction is in flight at a time, and every core request completes with exactly one ready pulse.

## Interface
Parameters:
- `N_CORES`, 4, number of requesting cores; range 2..8.
- `RAM_LATENCY`, 1, cycles the RAM inputs must be held before `ram_data_out` is valid; range 1..4.

Ports:
- `clock`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `core_req`  in  N_CORES  per-core `memory_transaction`; level held until that core's ready.
- `core_we`  in  N_CORES  per-core `mem_write`.
- `core_addr`  in  N_CORES*32  per-core `ALU_result`; core k occupies bits [32k+31:32k].
- `core_wdata`  in  N_CORES*128  per-core `data_out_bus`.
- `core_be`  in  N_CORES*16  per-core `byte_enablers`.
- `core_ready`  out  N_CORES  one-hot, one-cycle `data_ready` pulse to the served core.
- `resp_data`  out  128  read line, broadcast to all cores; valid while `core_ready` is nonzero.
- `ram_address`  out  20  RAM address, equal to `core_addr[k][19:0]`.
- `ram_data_in`  out  128  RAM write data.
- `ram_byte_enablers`  out  16  RAM byte enables.
- `ram_write_enable`  out  1  RAM write strobe.
- `ram_data_out`  in  128  RAM read data.

## Operation
- The FSM has three states: `IDLE`, `ACCESS`, `RESPOND`.
- `IDLE`:
  - If any `core_req` bit is set, pick the first requester at or after `rr_ptr`, scanning upward modulo `N_CORES`.
  - Register `grant`, address, data, BE and we; load `wait_cnt = RAM_LATENCY-1`; go to `ACCESS`.
  - With no request, stay in `IDLE`.
- `ACCESS`:
  - Drive the RAM outputs from the latched values.
  - `ram_write_enable` is high only in the first `ACCESS` cycle and only for a write.
  - When `wait_cnt == 0`, capture `ram_data_out` into `resp_data` and go to `RESPOND`. Otherwise decrement `wait_cnt`.
- `RESPOND`:
  - `core_ready[grant] = 1` for exactly this cycle.
  - `rr_ptr <= (grant+1) mod N_CORES`.
  - Go to `IDLE`. Requests are not sampled in this cycle.
- Writes also return the captured RAM line in `resp_data`; cores ignore it.
- Address handling: bits [31:20] are discarded with no fault. Byte enables pass through unmodified.

## Timing
- A request seen in `IDLE` at cycle t produces ready at cycle t+RAM_LATENCY+1. With the default latency this is t+2.
- RAM outputs are registered and change only on the `IDLE`→`ACCESS` edge.
- A core holding `core_req` high in the cycle after its ready is treated as a new request, i.e. the next instruction.
- A request that drops before it is granted is discarded; no ready is issued for it.
- With all cores requesting continuously, each core is served once every N_CORES*(RAM_LATENCY+2) cycles.
- Reset values:
  - state `IDLE`, `rr_ptr=0`, `grant=0`, `wait_cnt=0`.
  - `core_ready=0`, `resp_data=0`.
  - `ram_address=0`, `ram_data_in=0`, `ram_byte_enablers=0`, `ram_write_enable=0`.
- Reset asserted mid-transaction aborts it and no ready is issued. A write already strobed in its first `ACCESS` cycle remains committed.

## Configuration
- `SHARED_RAM_ARB_PERF_EN` defined:
  - Adds output `grant_count` (N_CORES*32), one saturating 32-bit counter per core, incremented in `RESPOND`.
  - Adds output `stall_count` (32), saturating, incremented each cycle in which some `core_req` bit is set but that core is not in `RESPOND`.
  - All counters reset to 0.
- Macro undefined: neither port nor counter exists, and the arbitration behaviour is identical.

## Structure
- Package `shared_ram_arb_pkg` holds:
  - `arb_state_t` enum.
  - `LINE_W=128`, `BE_W=16`, `RAM_ADDR_W=20`, `CORE_ADDR_W=32`.
- Sub-module `rr_picker`: purely combinational round-robin select taking `req` and `ptr`, producing `grant_idx` and `any`. It is instantiated once.

## Test plan
- Single read: core 1 reads addr 0x00040 with the RAM line preloaded to 0xDEAD…BEEF. Required: ready[1] at t+2 and `resp_data` equal to the line; other ready bits stay 0.
- Write then read: core 0 writes BE=0x000F with data 0x11223344 to 0x00010, then reads the same address. Required: bytes 3:0 updated, the rest unchanged, and exactly one write-enable cycle.
- Contention: all 4 cores request simultaneously after reset. Required: service order 0,1,2,3, with ready pulses at cycles 2,5,8,11.
- Fairness: core 3 requests continuously while core 0 requests only once. Required: the order is 0,3,3…; with `rr_ptr` at 1 and cores 0 and 3 pending, core 3 is served first.
- Reset during `ACCESS` of a read with `RAM_LATENCY`=3: all outputs return to 0, no ready is issued, and a fresh request is served normally afterwards.
- With `SHARED_RAM_ARB_PERF_EN` defined: after the contention test, `grant_count` is 1 per core and `stall_count` equals the summed waiting cycles.
